// File: rtl/pll_lock_reset_seq_if.sv
// Status/control bundle between the PLL lock reset sequencer and its user.
// master drives the lock flag and soft request; slave is the sequencer.
interface pll_lock_reset_seq_if;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       sys_rst;
    logic       ready;
    logic [7:0] lock_loss_cnt;

    modport master (
        output pll_locked,
        output soft_rst_req,
        input  sys_rst,
        input  ready,
        input  lock_loss_cnt
    );

    modport slave (
        input  pll_locked,
        input  soft_rst_req,
        output sys_rst,
        output ready,
        output lock_loss_cnt
    );
endinterface

// File: rtl/pll_lock_reset_seq.sv
// PLL lock qualifier and synchronous system-reset sequencer (WAIT_LOCK -> HOLD -> RUN).
// Define LOCK_LOSS_COUNT_EN to build the saturating lock-loss counter; otherwise it reads 0.
module pll_lock_reset_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RST_HOLD_CYCLES    = 16,
    parameter int CNT_W              = 16
) (
    input logic                 clk,
    input logic                 rst,
    pll_lock_reset_seq_if.slave bus
);

    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       stable_q, stable_d;
    logic [CNT_W-1:0]       hold_q, hold_d;
    logic                   sys_rst_q;
    logic                   ready_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        stable_d = stable_q;
        hold_d   = hold_q;
        case (state_q)
            ST_WAIT_LOCK: begin
                if (!locked_s) begin
                    stable_d = '0;
                end else if (stable_q == STABLE_LAST) begin
                    state_d  = ST_HOLD;
                    stable_d = '0;
                    hold_d   = '0;
                end else begin
                    stable_d = stable_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!locked_s) begin
                    state_d  = ST_WAIT_LOCK;
                    stable_d = '0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d = ST_RUN;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_RUN: begin
                // Lock loss outranks a simultaneous soft request.
                if (!locked_s) begin
                    state_d  = ST_WAIT_LOCK;
                    stable_d = '0;
                end else if (bus.soft_rst_req) begin
                    state_d = ST_HOLD;
                    hold_d  = '0;
                end
            end
            default: begin
                state_d  = ST_WAIT_LOCK;
                stable_d = '0;
                hold_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they change on the transition edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_WAIT_LOCK;
            stable_q  <= '0;
            hold_q    <= '0;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            stable_q  <= stable_d;
            hold_q    <= hold_d;
            sys_rst_q <= (state_d != ST_RUN);
            ready_q   <= (state_d == ST_RUN);
        end
    end

    assign bus.sys_rst = sys_rst_q;
    assign bus.ready   = ready_q;

`ifdef LOCK_LOSS_COUNT_EN
    logic       loss_evt;
    logic [7:0] loss_cnt_q;

    assign loss_evt = (state_q == ST_RUN) && !locked_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loss_cnt_q <= '0;
        end else if (loss_evt && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_q <= loss_cnt_q + 1'b1;
        end
    end

    assign bus.lock_loss_cnt = loss_cnt_q;
`else
    assign bus.lock_loss_cnt = 8'h00;
`endif

endmodule
